// File: rtl/mem_link_pkg.sv
// mem_link_pkg: shared definitions for the UART memory link.
// Holds message lengths, field offsets, the master FSM state type and
// helpers that pack read/write request messages (72-bit body, byte 0 in [7:0]).
package mem_link_pkg;

  localparam logic [4:0] REQ_RD_LEN = 5'd5;
  localparam logic [4:0] REQ_WR_LEN = 5'd9;
  localparam logic [4:0] RSP_RD_LEN = 5'd4;

  localparam int unsigned ADDR_LO = 32;
  localparam int unsigned MASK_LO = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_SEND,
    ST_WAIT_RSP,
    ST_POP,
    ST_RESP
  } state_e;

  // Read request: address in bytes 0..3, byte 4 left zero to mark a read.
  function automatic logic [71:0] pack_rd_req(input logic [31:0] addr);
    logic [71:0] msg;
    msg        = '0;
    msg[31:0]  = addr;
    return msg;
  endfunction

  // Write request: data, then address, then byte enables in the low nibble of byte 8.
  function automatic logic [71:0] pack_wr_req(input logic [31:0] addr,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  mask);
    logic [71:0] msg;
    msg                  = '0;
    msg[31:0]            = wdata;
    msg[ADDR_LO +: 32]   = addr;
    msg[MASK_LO +: 4]    = mask;
    return msg;
  endfunction

endpackage

// File: rtl/mem_link_master.sv
// mem_link_master: CPU-side master of the UART memory link.
// Takes one load/store from the core, packs it into a request message on
// link channel 0, and for loads waits for the 4-byte reply (with timeout).
// Ports:
//   CLK, RST (async, active-high)
//   cpu_req_*   : core request (valid/ready, we, addr, wdata, mask)
//   cpu_resp_*  : one-cycle completion pulse with rdata/err
//   link_write_*: message push towards the link (flag, length, data, writable)
//   link_read_* : received message pop (flag, length, data, readable)
// All outputs are registered. link_writable/link_readable are acted on in the
// cycle after they are sampled, so pushes/pops appear one cycle later.
module mem_link_master
  import mem_link_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned CNT_WIDTH      = 20
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        cpu_req_valid,
  output logic        cpu_req_ready,
  input  logic        cpu_req_we,
  input  logic [31:0] cpu_req_addr,
  input  logic [31:0] cpu_req_wdata,
  input  logic [3:0]  cpu_req_mask,
  output logic        cpu_resp_valid,
  output logic [31:0] cpu_resp_rdata,
  output logic        cpu_resp_err,
  output logic        link_write_flag,
  output logic [4:0]  link_write_length,
  output logic [71:0] link_write_data,
  input  logic        link_writable,
  output logic        link_read_flag,
  input  logic [4:0]  link_read_length,
  input  logic [71:0] link_read_data,
  input  logic        link_readable
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  store_q, store_d;
  logic                  req_ready_q, req_ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  wr_flag_q, wr_flag_d;
  logic [4:0]            wr_len_q, wr_len_d;
  logic [71:0]           wr_data_q, wr_data_d;
  logic                  rd_flag_q, rd_flag_d;

  // Only the low word of a reply carries load data.
  logic unused_rd_hi;
  assign unused_rd_hi = ^link_read_data[71:32];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    store_d      = store_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    wr_len_d     = wr_len_q;
    wr_data_d    = wr_data_q;
    wr_flag_d    = 1'b0;
    rd_flag_d    = 1'b0;
    resp_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (link_readable) begin
          // Stale reply from an abandoned transaction: pop and discard.
          rd_flag_d = 1'b1;
          state_d   = ST_DRAIN;
        end else if (cpu_req_valid && req_ready_q) begin
          store_d = cpu_req_we;
          rdata_d = '0;
          err_d   = 1'b0;
          if (cpu_req_we && (cpu_req_mask == 4'b0000)) begin
            resp_valid_d = 1'b1;
            state_d      = ST_RESP;
          end else begin
            if (cpu_req_we) begin
              wr_len_d  = REQ_WR_LEN;
              wr_data_d = pack_wr_req(cpu_req_addr, cpu_req_wdata, cpu_req_mask);
            end else begin
              wr_len_d  = REQ_RD_LEN;
              wr_data_d = pack_rd_req(cpu_req_addr);
            end
            wr_flag_d = link_writable;
            state_d   = ST_SEND;
          end
        end
      end

      ST_DRAIN: state_d = ST_IDLE;

      ST_SEND: begin
        // wr_flag_q high means the push happens in this cycle.
        if (wr_flag_q) begin
          if (store_q) begin
            resp_valid_d = 1'b1;
            state_d      = ST_RESP;
          end else begin
            cnt_d   = '0;
            state_d = ST_WAIT_RSP;
          end
        end else begin
          wr_flag_d = link_writable;
        end
      end

      ST_WAIT_RSP: begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
        if (link_readable) begin
          rd_flag_d = 1'b1;
          state_d   = ST_POP;
          if (link_read_length == RSP_RD_LEN) begin
            rdata_d = link_read_data[31:0];
            err_d   = 1'b0;
          end else begin
            rdata_d = '0;
            err_d   = 1'b1;
          end
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
          rdata_d      = '0;
          err_d        = 1'b1;
          resp_valid_d = 1'b1;
          state_d      = ST_RESP;
        end
      end

      ST_POP: begin
        resp_valid_d = 1'b1;
        state_d      = ST_RESP;
      end

      ST_RESP: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    req_ready_d = (state_d == ST_IDLE) && !link_readable;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      store_q      <= 1'b0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      wr_flag_q    <= 1'b0;
      wr_len_q     <= '0;
      wr_data_q    <= '0;
      rd_flag_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      store_q      <= store_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      wr_flag_q    <= wr_flag_d;
      wr_len_q     <= wr_len_d;
      wr_data_q    <= wr_data_d;
      rd_flag_q    <= rd_flag_d;
    end
  end

  assign cpu_req_ready     = req_ready_q;
  assign cpu_resp_valid    = resp_valid_q;
  assign cpu_resp_rdata    = rdata_q;
  assign cpu_resp_err      = err_q;
  assign link_write_flag   = wr_flag_q;
  assign link_write_length = wr_len_q;
  assign link_write_data   = wr_data_q;
  assign link_read_flag    = rd_flag_q;

endmodule

// File: tb/tb_mem_link_master.sv
module tb_mem_link_master;

  localparam int unsigned TO = 64;

  logic        CLK = 1'b0;
  logic        RST;
  logic        cpu_req_valid, cpu_req_ready, cpu_req_we;
  logic [31:0] cpu_req_addr, cpu_req_wdata;
  logic [3:0]  cpu_req_mask;
  logic        cpu_resp_valid;
  logic [31:0] cpu_resp_rdata;
  logic        cpu_resp_err;
  logic        link_write_flag;
  logic [4:0]  link_write_length;
  logic [71:0] link_write_data;
  logic        link_writable, link_read_flag;
  logic [4:0]  link_read_length;
  logic [71:0] link_read_data;
  logic        link_readable;

  always #5 CLK = ~CLK;

  mem_link_master #(.TIMEOUT_CYCLES(TO), .CNT_WIDTH(7)) dut (
    .CLK(CLK), .RST(RST),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_req_we(cpu_req_we), .cpu_req_addr(cpu_req_addr),
    .cpu_req_wdata(cpu_req_wdata), .cpu_req_mask(cpu_req_mask),
    .cpu_resp_valid(cpu_resp_valid), .cpu_resp_rdata(cpu_resp_rdata),
    .cpu_resp_err(cpu_resp_err),
    .link_write_flag(link_write_flag), .link_write_length(link_write_length),
    .link_write_data(link_write_data), .link_writable(link_writable),
    .link_read_flag(link_read_flag), .link_read_length(link_read_length),
    .link_read_data(link_read_data), .link_readable(link_readable)
  );

  int unsigned checks = 0, errors = 0;
  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Link-side observer and simulated memory (written only from DUT messages).
  int unsigned wr_cnt = 0, rd_cnt = 0, resp_cnt = 0;
  int unsigned wr_cyc = 0, rd_cyc = 0, resp_cyc = 0;
  logic [4:0]  wr_len;
  logic [71:0] wr_data;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [7:0]  mem [0:1023];
  logic [7:0]  ref_mem [0:1023];
  bit          mem_init = 0;

  always @(negedge CLK) begin
    if (!mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'(i * 7 + 3);
      mem_init <= 1;
    end
    if (link_write_flag) begin
      wr_cnt  <= wr_cnt + 1;
      wr_cyc  <= cyc;
      wr_len  <= link_write_length;
      wr_data <= link_write_data;
      if (link_write_length == 5'd9)
        for (int b = 0; b < 4; b++)
          if (link_write_data[64 + b])
            mem[link_write_data[41:32] + 10'(b)] <= link_write_data[8*b +: 8];
    end
    if (link_read_flag) begin
      rd_cnt <= rd_cnt + 1;
      rd_cyc <= cyc;
    end
    if (cpu_resp_valid) begin
      resp_cnt   <= resp_cnt + 1;
      resp_cyc   <= cyc;
      resp_rdata <= cpu_resp_rdata;
      resp_err   <= cpu_resp_err;
    end
  end

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int unsigned a);
    return 32'(ref_mem[a]) + (32'(ref_mem[a+1]) << 8) +
           (32'(ref_mem[a+2]) << 16) + (32'(ref_mem[a+3]) << 24);
  endfunction

  task automatic ref_store(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] mask);
    logic [31:0] d;
    d = wdata;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) ref_mem[addr + b] = 8'(d % 256);
      d = d / 256;
    end
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] mask, output int unsigned acc, output bit ok);
    ok = 0;
    acc = 0;
    for (int t = 0; t < 100; t++) begin
      if (cpu_req_ready === 1'b1 && !link_readable) begin ok = 1; break; end
      tick();
    end
    chk("req_ready_wait", 72'(ok), 72'(1));
    if (ok) begin
      cpu_req_valid = 1; cpu_req_we = we; cpu_req_addr = addr;
      cpu_req_wdata = wdata; cpu_req_mask = mask;
      acc = cyc;
      tick();
      cpu_req_valid = 0;
    end
  endtask

  // Full transaction against the reference: message contents, latency, response.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] mask, input int unsigned dly, input logic [4:0] rlen);
    int unsigned acc, m, w0, rd0, rs0, exp_rcyc;
    bit ok;
    logic [71:0] exp_msg;
    logic [31:0] exp_rd, word;
    logic exp_err, nosend;
    w0 = wr_cnt; rd0 = rd_cnt; rs0 = resp_cnt;
    m = 0;
    nosend = we && (mask == 4'b0000);
    issue(we, addr, wdata, mask, acc, ok);
    if (!ok) return;
    if (we) begin
      ref_store(addr, wdata, mask);
      exp_msg = 72'(wdata) + (72'(addr) << 32) + (72'(mask) << 64);
    end else begin
      exp_msg = 72'(addr);
    end
    exp_rd = 0; exp_err = 0;
    if (!nosend) begin
      for (int t = 0; t < 100 && wr_cnt == w0; t++) tick();
      chk("wr_seen", 72'(wr_cnt - w0), 72'(1));
      chk("wr_len", 72'(wr_len), we ? 72'(9) : 72'(5));
      chk("wr_data", wr_data, exp_msg);
      chk("wr_cycle", 72'(wr_cyc), 72'(acc + 1));
      if (!we) begin
        repeat (dly) tick();
        word = {mem[addr+3], mem[addr+2], mem[addr+1], mem[addr]};
        link_read_length = rlen;
        link_read_data   = {8'($urandom), 32'($urandom), word};
        link_readable    = 1;
        m = cyc;
        for (int t = 0; t < 100 && rd_cnt == rd0; t++) tick();
        @(posedge CLK); #1;
        link_readable = 0;
        chk("rd_cycle", 72'(rd_cyc), 72'(m + 1));
        if (rlen == 5'd4) exp_rd = ref_word(addr);
        else exp_err = 1;
      end
    end
    for (int t = 0; t < 300 && resp_cnt == rs0; t++) tick();
    repeat (3) tick();
    exp_rcyc = nosend ? acc + 1 : (we ? acc + 2 : m + 2);
    chk("resp_count", 72'(resp_cnt - rs0), 72'(1));
    chk("resp_cycle", 72'(resp_cyc), 72'(exp_rcyc));
    chk("resp_rdata", 72'(resp_rdata), 72'(exp_rd));
    chk("resp_err", 72'(resp_err), 72'(exp_err));
    chk("rd_pops", 72'(rd_cnt - rd0), (we ? 72'(0) : 72'(1)));
    chk("wr_pushes", 72'(wr_cnt - w0), (nosend ? 72'(0) : 72'(1)));
  endtask

  initial begin : main
    int unsigned acc, w0, rd0, rs0, m;
    bit ok, bp_flag, bp_ready, bp_data;
    logic [7:0] b105, b107;
    logic [71:0] exp_msg;
    logic we;
    logic [4:0] rlen;

    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'(i * 7 + 3);
    RST = 1; cpu_req_valid = 0; cpu_req_we = 0; cpu_req_addr = 0;
    cpu_req_wdata = 0; cpu_req_mask = 0; link_writable = 1;
    link_read_length = 0; link_read_data = 0; link_readable = 0;
    repeat (3) tick();
    chk("reset_ctrl", 72'({cpu_req_ready, cpu_resp_valid, cpu_resp_err, link_write_flag,
                           link_read_flag, link_write_length}), 72'(0));
    chk("reset_rdata", 72'(cpu_resp_rdata), 72'(0));
    chk("reset_wdata", link_write_data, 72'(0));
    RST = 0;
    tick(); tick();
    chk("ready_after_reset", 72'(cpu_req_ready), 72'(1));

    // Directed load of a known word after a 50-cycle reply delay.
    run_txn(1, 32'h10, 32'h12345678, 4'hF, 0, 5'd4);
    run_txn(0, 32'h10, 32'h0, 4'h0, 50, 5'd4);
    chk("load_0x10_value", 72'(resp_rdata), 72'h12345678);

    // Partial store: only bytes 0x104 and 0x106 change.
    b105 = mem[32'h105]; b107 = mem[32'h107];
    run_txn(1, 32'h104, 32'hAABBCCDD, 4'b0101, 0, 5'd4);
    chk("store_msg", wr_data, 72'h5_00000104_AABBCCDD);
    chk("mem_104", 72'(mem[32'h104]), 72'hDD);
    chk("mem_105", 72'(mem[32'h105]), 72'(b105));
    chk("mem_106", 72'(mem[32'h106]), 72'hBB);
    chk("mem_107", 72'(mem[32'h107]), 72'(b107));

    // Backpressure: writable low for 20 cycles during a store.
    link_writable = 0;
    w0 = wr_cnt; rs0 = resp_cnt;
    issue(1, 32'h200, 32'h11223344, 4'hF, acc, ok);
    ref_store(32'h200, 32'h11223344, 4'hF);
    exp_msg = 72'h11223344 + (72'h200 << 32) + (72'hF << 64);
    bp_flag = 0; bp_ready = 0; bp_data = 0;
    for (int t = 0; t < 20; t++) begin
      if (link_write_flag !== 1'b0) bp_flag = 1;
      if (cpu_req_ready !== 1'b0) bp_ready = 1;
      if (link_write_data !== exp_msg || link_write_length !== 5'd9) bp_data = 1;
      tick();
    end
    chk("bp_no_flag", 72'(bp_flag), 72'(0));
    chk("bp_ready_low", 72'(bp_ready), 72'(0));
    chk("bp_data_stable", 72'(bp_data), 72'(0));
    link_writable = 1;
    m = cyc;
    for (int t = 0; t < 20 && wr_cnt == w0; t++) tick();
    chk("bp_flag_cycle", 72'(wr_cyc), 72'(m + 1));
    for (int t = 0; t < 20 && resp_cnt == rs0; t++) tick();
    repeat (3) tick();
    chk("bp_push_once", 72'(wr_cnt - w0), 72'(1));
    chk("bp_resp", 72'({resp_err, 8'(resp_cnt - rs0)}), 72'(1));

    // Bad reply length.
    run_txn(0, 32'h40, 0, 0, 5, 5'd5);

    // Store with empty mask: completes without touching the link.
    run_txn(1, 32'h300, 32'hCAFEF00D, 4'h0, 0, 5'd4);

    // Timeout then late reply drained in IDLE.
    w0 = wr_cnt; rd0 = rd_cnt; rs0 = resp_cnt;
    issue(0, 32'h80, 0, 0, acc, ok);
    for (int t = 0; t < 300 && resp_cnt == rs0; t++) tick();
    chk("to_resp_cycle", 72'(resp_cyc), 72'(acc + 2 + TO));
    chk("to_err", 72'(resp_err), 72'(1));
    chk("to_rdata", 72'(resp_rdata), 72'(0));
    chk("to_no_pop", 72'(rd_cnt - rd0), 72'(0));
    rs0 = resp_cnt;
    link_read_length = 5'd4; link_read_data = 72'h77; link_readable = 1;
    tick();
    chk("drain_ready_low", 72'(cpu_req_ready), 72'(0));
    for (int t = 0; t < 20 && rd_cnt == rd0; t++) tick();
    @(posedge CLK); #1;
    link_readable = 0;
    ok = 0;
    for (int t = 0; t < 6; t++) begin
      if (cpu_req_ready === 1'b1) begin ok = 1; break; end
      tick();
    end
    chk("drain_ready_back", 72'(ok), 72'(1));
    chk("drain_pop_once", 72'(rd_cnt - rd0), 72'(1));
    chk("drain_no_resp", 72'(resp_cnt - rs0), 72'(0));

    // Reset while waiting for a read reply.
    w0 = wr_cnt;
    issue(0, 32'h90, 0, 0, acc, ok);
    for (int t = 0; t < 20 && wr_cnt == w0; t++) tick();
    repeat (5) tick();
    RST = 1;
    #1;
    chk("rst_mid_ctrl", 72'({cpu_req_ready, cpu_resp_valid, cpu_resp_err, link_write_flag,
                             link_read_flag, link_write_length}), 72'(0));
    chk("rst_mid_rdata", 72'(cpu_resp_rdata), 72'(0));
    chk("rst_mid_wdata", link_write_data, 72'(0));
    tick();
    RST = 0;
    rd0 = rd_cnt; rs0 = resp_cnt;
    link_read_length = 5'd4; link_read_data = 72'hDEADBEEF; link_readable = 1;
    for (int t = 0; t < 20 && rd_cnt == rd0; t++) tick();
    @(posedge CLK); #1;
    link_readable = 0;
    repeat (3) tick();
    chk("rst_abandoned_pop", 72'(rd_cnt - rd0), 72'(1));
    chk("rst_abandoned_no_resp", 72'(resp_cnt - rs0), 72'(0));
    run_txn(0, 32'h104, 0, 0, 3, 5'd4);

    // Random mix against the reference memory.
    for (int i = 0; i < 30; i++) begin
      we = 1'($urandom % 2);
      rlen = ($urandom % 6 == 0) ? 5'd7 : 5'd4;
      run_txn(we, 32'(($urandom % 255) * 4), 32'($urandom), 4'($urandom % 16),
              $urandom % 20, rlen);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
